// File: rtl/ml_mod_pkg.sv
// Shared widths, state encoding and packing helpers for the MIMO QPSK modulator.
// Fixed-point convention throughout: signed Q4.16 in DW bits.
package ml_mod_pkg;

   localparam int DW     = 20;
   localparam int ACC_W  = 24;
   localparam int PW     = 42;
   localparam int RW     = 320;
   localparam int YW     = 160;
   localparam int A_Q16  = 46341;
   localparam int Y_MAX  = (1 << (DW - 1)) - 1;
   localparam int Y_MIN  = -(1 << (DW - 1));

   typedef enum logic [1:0] {
      ST_COLLECT,
      ST_CALC,
      ST_EMIT,
      ST_HOLD
   } mod_state_t;

   // Offset of r(k,j) in the packed R vector; k and j are 0-based with j >= k.
   function automatic int r_offset(input int k, input int j);
      int base;
      case (k)
         0:       base = 0;
         1:       base = 140;
         2:       base = 240;
         default: base = 300;
      endcase
      return (j == k) ? base : base + DW + 2 * DW * (j - k - 1);
   endfunction

   function automatic int y_offset(input int k);
      return 2 * DW * k;
   endfunction

   // Multiply by 1/sqrt(2) with round-half-up, add optional noise, then clamp.
   function automatic logic [DW-1:0] scale_sat(input logic signed [ACC_W-1:0] s,
                                               input logic signed [3:0] n);
      logic signed [PW-1:0] p;
      p = PW'(s) * PW'(A_Q16);
      p = (p + PW'(32768)) >>> 16;
      p = p + PW'(n);
      if (p > PW'(Y_MAX))
         return DW'(Y_MAX);
      else if (p < PW'(Y_MIN))
         return DW'(Y_MIN);
      else
         return p[DW-1:0];
   endfunction

endpackage

// File: rtl/ml_modulator_if.sv
// Bit-stream handshake and frame output bundle of the modulator.
// The master side feeds bits and R; the slave side is the modulator itself.
interface ml_modulator_if;
   import ml_mod_pkg::*;

   logic          i_bit;
   logic          i_bit_vld;
   logic          o_bit_rdy;
   logic [RW-1:0] i_r;
   logic          o_trig;
   logic [YW-1:0] o_y_hat;
   logic [RW-1:0] o_r;

   modport master (
      output i_bit, i_bit_vld, i_r,
      input  o_bit_rdy, o_trig, o_y_hat, o_r
   );

   modport slave (
      input  i_bit, i_bit_vld, i_r,
      output o_bit_rdy, o_trig, o_y_hat, o_r
   );

endinterface

// File: rtl/ml_mod_row.sv
// Combinational row engine: y_k = A * sum_{j>=k} r_kj * x_j using add/sub only.
// With ML_MOD_NOISE_EN defined, small LFSR noise is injected before saturation.
module ml_mod_row
   import ml_mod_pkg::*;
(
   input  logic [3:0][DW-1:0] r_re,
   input  logic [3:0][DW-1:0] r_im,
   input  logic [3:0]         x_re_neg,
   input  logic [3:0]         x_im_neg,
   input  logic [1:0]         row_idx,
`ifdef ML_MOD_NOISE_EN
   input  logic [3:0]         noise_re,
   input  logic [3:0]         noise_im,
`endif
   output logic [2*DW-1:0]    y
);

   logic signed [ACC_W-1:0] acc_re;
   logic signed [ACC_W-1:0] acc_im;
   logic signed [ACC_W-1:0] a;
   logic signed [ACC_W-1:0] b;
   logic signed [3:0]       n_re;
   logic signed [3:0]       n_im;

   // QPSK symbols are +/-1 so each complex product collapses to sign flips.
   always_comb begin
      acc_re = '0;
      acc_im = '0;
      a      = '0;
      b      = '0;
      for (int j = 0; j < 4; j++) begin
         a = ACC_W'($signed(r_re[j]));
         b = (j == int'(row_idx)) ? '0 : ACC_W'($signed(r_im[j]));
         if (j >= int'(row_idx)) begin
            acc_re = acc_re + (x_re_neg[j] ? -a : a) - (x_im_neg[j] ? -b : b);
            acc_im = acc_im + (x_im_neg[j] ? -a : a) + (x_re_neg[j] ? -b : b);
         end
      end
   end

`ifdef ML_MOD_NOISE_EN
   assign n_re = $signed(noise_re);
   assign n_im = $signed(noise_im);
`else
   assign n_re = '0;
   assign n_im = '0;
`endif

   assign y = {scale_sat(acc_im, n_im), scale_sat(acc_re, n_re)};

endmodule

// File: rtl/ml_modulator.sv
// Top of the QPSK MIMO modulator: collects 8 bits, computes y = A*R*x row by row,
// emits a trigger frame, then idles GAP cycles. Optional noise: ML_MOD_NOISE_EN.
module ml_modulator
   import ml_mod_pkg::*;
#(
   parameter int GAP = 64
)
(
   input  logic           i_clk,
   input  logic           i_reset,
   ml_modulator_if.slave  mod_bus
);

   localparam int HW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [HW-1:0] HOLD_LAST = (GAP > 0) ? HW'(GAP - 1) : '0;

   mod_state_t             state;
   mod_state_t             next_state;
   logic [2:0]             bit_cnt;
   logic [7:0]             bits;
   logic [RW-1:0]          r_cap;
   logic [1:0]             row_idx;
   logic [HW-1:0]          hold_cnt;
   logic [3:0][2*DW-1:0]   y_work;
   logic [YW-1:0]          y_hat_q;
   logic [RW-1:0]          r_out_q;
   logic                   bit_rdy;
   logic                   trig;
   logic                   xfer;
   logic                   last_bit;

   logic [3:0][DW-1:0]     row_re;
   logic [3:0][DW-1:0]     row_im;
   logic [3:0]             x_re_neg;
   logic [3:0]             x_im_neg;
   logic [2*DW-1:0]        row_y;

   assign xfer     = bit_rdy && mod_bus.i_bit_vld;
   assign last_bit = xfer && (bit_cnt == 3'd7);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         state <= ST_COLLECT;
      else
         state <= next_state;
   end

   // Next state plus the two status strobes derived directly from the state.
   always_comb begin
      next_state = state;
      bit_rdy    = 1'b0;
      trig       = 1'b0;
      case (state)
         ST_COLLECT: begin
            bit_rdy = 1'b1;
            if (last_bit)
               next_state = ST_CALC;
         end
         ST_CALC: begin
            if (row_idx == 2'd3)
               next_state = ST_EMIT;
         end
         ST_EMIT: begin
            trig       = 1'b1;
            next_state = (GAP == 0) ? ST_COLLECT : ST_HOLD;
         end
         ST_HOLD: begin
            if (hold_cnt == HOLD_LAST)
               next_state = ST_COLLECT;
         end
         default: next_state = ST_COLLECT;
      endcase
   end

   // Frame datapath: bit capture, per-row results, and the published outputs.
   // The final row bypasses y_work so the output frame is complete on EMIT entry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         bit_cnt  <= '0;
         bits     <= '0;
         r_cap    <= '0;
         row_idx  <= '0;
         hold_cnt <= '0;
         y_work   <= '0;
         y_hat_q  <= '0;
         r_out_q  <= '0;
      end else begin
         case (state)
            ST_COLLECT: begin
               if (xfer) begin
                  bits[bit_cnt] <= mod_bus.i_bit;
                  bit_cnt       <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     r_cap   <= mod_bus.i_r;
                     row_idx <= '0;
                  end
               end
            end
            ST_CALC: begin
               y_work[row_idx] <= row_y;
               row_idx         <= row_idx + 2'd1;
               if (row_idx == 2'd3) begin
                  y_hat_q <= {row_y, y_work[2], y_work[1], y_work[0]};
                  r_out_q <= r_cap;
               end
            end
            ST_EMIT: hold_cnt <= '0;
            ST_HOLD: hold_cnt <= hold_cnt + HW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      row_re   = '0;
      row_im   = '0;
      x_re_neg = '0;
      x_im_neg = '0;
      for (int j = 0; j < 4; j++) begin
         x_re_neg[j] = bits[2*j];
         x_im_neg[j] = bits[2*j+1];
         if (j >= int'(row_idx)) begin
            row_re[j] = r_cap[r_offset(int'(row_idx), j) +: DW];
            if (j != int'(row_idx))
               row_im[j] = r_cap[r_offset(int'(row_idx), j) + DW +: DW];
         end
      end
   end

`ifdef ML_MOD_NOISE_EN
   logic [15:0] lfsr;

   // Galois LFSR advances once per computed row so each row sees fresh noise.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         lfsr <= 16'hACE1;
      else if (state == ST_CALC)
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end
`endif

   ml_mod_row u_row (
      .r_re     (row_re),
      .r_im     (row_im),
      .x_re_neg (x_re_neg),
      .x_im_neg (x_im_neg),
      .row_idx  (row_idx),
`ifdef ML_MOD_NOISE_EN
      .noise_re (lfsr[3:0]),
      .noise_im (lfsr[7:4]),
`endif
      .y        (row_y)
   );

   assign mod_bus.o_bit_rdy = bit_rdy;
   assign mod_bus.o_trig    = trig;
   assign mod_bus.o_y_hat   = y_hat_q;
   assign mod_bus.o_r       = r_out_q;

endmodule

// File: tb/tb_ml_modulator.sv
// Directed self-checking bench for ml_modulator (noiseless build, GAP = 64).
module tb_ml_modulator;
   import ml_mod_pkg::*;

   logic i_clk = 1'b0;
   logic i_reset = 1'b0;
   int   cyc = 0;
   int   compare_cnt = 0;
   int   mismatch_cnt = 0;

   ml_modulator_if mod_bus();

   ml_modulator #(.GAP(64)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .mod_bus (mod_bus)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [319:0] observed,
                              input logic [319:0] expected);
      compare_cnt++;
      if (observed !== expected) begin
         mismatch_cnt++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [39:0] yk(input int re, input int im);
      logic [19:0] r20;
      logic [19:0] i20;
      r20 = 20'(re);
      i20 = 20'(im);
      return {i20, r20};
   endfunction

   function automatic logic [319:0] mk_r(input int diag, input int off_re, input int off_im);
      logic [319:0] r;
      logic [39:0]  off;
      logic [19:0]  d;
      d   = 20'(diag);
      off = {20'(off_im), 20'(off_re)};
      r = '0;
      r[19:0]    = d;
      r[59:20]   = off;
      r[99:60]   = off;
      r[139:100] = off;
      r[159:140] = d;
      r[199:160] = off;
      r[239:200] = off;
      r[259:240] = d;
      r[299:260] = off;
      r[319:300] = d;
      return r;
   endfunction

   // Feed 8 bits (b0 first); e_cyc is the cycle stamp of the 8th transfer edge.
   task automatic applyStimulus(input logic [7:0] bits8, input logic [319:0] r,
                                output int e_cyc);
      int wait_n;
      mod_bus.i_r       = r;
      mod_bus.i_bit_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mod_bus.i_bit = bits8[i];
         wait_n = 0;
         while (!mod_bus.o_bit_rdy && wait_n < 300) begin
            @(posedge i_clk); #1;
            wait_n++;
         end
         if (wait_n >= 300)
            checkOutput("rdy_timeout", 0, 1);
         @(posedge i_clk); #1;
      end
      e_cyc = cyc;
      mod_bus.i_bit_vld = 1'b0;
   endtask

   task automatic waitTrig(output int t);
      int n;
      n = 0;
      t = -1;
      while (!mod_bus.o_trig && n < 100) begin
         @(posedge i_clk); #1;
         n++;
      end
      if (mod_bus.o_trig)
         t = cyc;
      else
         checkOutput("trig_timeout", 0, 1);
   endtask

   task automatic runFrame(input string tag, input logic [7:0] bits8,
                           input logic [319:0] r, input logic [159:0] exp_y);
      int e;
      int t;
      applyStimulus(bits8, r, e);
      mod_bus.i_r = ~r;
      waitTrig(t);
      checkOutput({tag, "_latency"}, t - e, 4);
      checkOutput({tag, "_y"}, mod_bus.o_y_hat, exp_y);
      checkOutput({tag, "_r"}, mod_bus.o_r, r);
      @(posedge i_clk); #1;
      checkOutput({tag, "_trig_1cyc"}, mod_bus.o_trig, 0);
      checkOutput({tag, "_y_hold"}, mod_bus.o_y_hat, exp_y);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [319:0] ident;
      logic [319:0] big;
      logic [159:0] y_pos;
      logic [159:0] y_neg;
      logic [159:0] y_pat;
      logic [159:0] y_sat;
      logic [159:0] prev_y;
      int e;
      int n;
      int last_trig;
      int low_run;
      int n_trig;
      int bad_y;

      ident = mk_r(65536, 0, 0);
      big   = mk_r(524287, 524287, 524287);
      y_pos = {4{yk(46341, 46341)}};
      y_neg = {4{yk(-46341, -46341)}};
      y_pat = {yk(46341, 46341), yk(-46341, -46341), yk(46341, -46341), yk(-46341, 46341)};
      y_sat = {yk(370727, 370727), yk(370727, 524287), yk(370727, 524287), yk(370727, 524287)};

      mod_bus.i_bit     = 1'b0;
      mod_bus.i_bit_vld = 1'b0;
      mod_bus.i_r       = '0;

      #2 i_reset = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("reset_trig", mod_bus.o_trig, 0);
      checkOutput("reset_y", mod_bus.o_y_hat, 0);
      checkOutput("reset_r", mod_bus.o_r, 0);
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      checkOutput("reset_rdy", mod_bus.o_bit_rdy, 1);
      checkOutput("reset_trig_after", mod_bus.o_trig, 0);

      runFrame("ident_00", 8'h00, ident, y_pos);
      runFrame("ident_ff", 8'hFF, ident, y_neg);
      runFrame("ident_39", 8'h39, ident, y_pat);
      runFrame("sat", 8'h00, big, y_sat);

      // Reset during the second CALC cycle must abandon the frame.
      applyStimulus(8'h00, ident, e);
      @(posedge i_clk); #1;
      i_reset = 1'b1;
      #1;
      checkOutput("midrst_trig", mod_bus.o_trig, 0);
      checkOutput("midrst_y", mod_bus.o_y_hat, 0);
      checkOutput("midrst_r", mod_bus.o_r, 0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      checkOutput("midrst_rdy", mod_bus.o_bit_rdy, 1);
      n = 0;
      repeat (20) begin
         @(posedge i_clk); #1;
         if (mod_bus.o_trig) n++;
      end
      checkOutput("midrst_no_trig", n, 0);
      runFrame("after_rst", 8'h39, ident, y_pat);

      // Streaming: valid held high for 300 cycles with alternating bits.
      n = 0;
      while (!mod_bus.o_bit_rdy && n < 300) begin
         @(posedge i_clk); #1;
         n++;
      end
      checkOutput("stream_start_rdy", mod_bus.o_bit_rdy, 1);
      mod_bus.i_r       = ident;
      mod_bus.i_bit_vld = 1'b1;
      prev_y    = mod_bus.o_y_hat;
      last_trig = -1;
      low_run   = 0;
      n_trig    = 0;
      bad_y     = 0;
      for (int c = 0; c < 300; c++) begin
         mod_bus.i_bit = (c % 2 == 1);
         @(posedge i_clk); #1;
         if (mod_bus.o_trig) begin
            if (last_trig >= 0)
               checkOutput("stream_period", cyc - last_trig, 77);
            last_trig = cyc;
            n_trig++;
         end
         if (mod_bus.o_y_hat !== prev_y && !mod_bus.o_trig)
            bad_y++;
         prev_y = mod_bus.o_y_hat;
         if (!mod_bus.o_bit_rdy)
            low_run++;
         else if (low_run > 0) begin
            checkOutput("stream_rdy_low", low_run, 69);
            low_run = 0;
         end
      end
      mod_bus.i_bit_vld = 1'b0;
      checkOutput("stream_y_only_on_trig", bad_y, 0);
      checkOutput("stream_trig_count", (n_trig >= 3) ? 1 : 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
      $finish;
   end

endmodule

// File: doc/ml_modulator.md
# ml_modulator

Transmit-side MIMO QPSK modulator and channel model that produces stimulus for the 4x4 ML demodulator. It accepts a serial bit stream through a valid/ready handshake and groups 8 bits into four QPSK symbols x1..x4. It computes y = A·R·x, where R is upper-triangular and A = 1/√2. It then presents y, together with the R used, as a one-cycle trigger plus a 160-bit y vector and a 320-bit R vector. Trigger spacing is guaranteed to cover the demodulator's 64-cycle search.

## Interface
- GAP, 64: minimum idle cycles after each o_trig before new bits are accepted.
- i_clk  in  1  clock; every register is rising-edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_bit  in  1  data bit.
- i_bit_vld  in  1  i_bit valid.
- o_bit_rdy  out  1  ready; a bit transfers when i_bit_vld && o_bit_rdy.
- i_r  in  320  channel matrix, sampled on the 8th bit transfer.
- o_trig  out  1  one-cycle pulse; o_y_hat and o_r are valid from this cycle.
- o_y_hat  out  160  y1..y4.
- o_r  out  320  registered copy of the sampled i_r.

## Operation
- Number format: every scalar is signed 20-bit Q4.16 (1.0 = 65536).
- i_r packing, starting at the LSB: r11, r12, r13, r14, r22, r23, r24, r33, r34, r44.
  - Diagonal entries are real and 20 bits wide.
  - Off-diagonal entries are complex and 40 bits wide: re in [19:0], im in [39:20].
- o_y_hat packing: yk at [40k-1:40k-40], with re in the low 20 bits and im in the high 20 bits.
- Bits: the first accepted bit is b0. Symbol xk takes re bit b(2k-2) and im bit b(2k-1). A bit value of 0 maps to +1 and 1 maps to -1.
- Row k sum, with p,q = ±1 the re/im signs of xj and a+jb = rkj:
  - re term = a·p - b·q; im term = a·q + b·p; both summed over j = k..4.
  - For the diagonal entry, b = 0.
  - Accumulators are 24-bit signed, so there is no overflow.
  - The row logic uses adders and subtractors only; there are no general multipliers.
- Scaling: y = (s·46341 + 32768) >>> 16, arithmetic shift. The result saturates to [-524288, 524287].
- FSM states:
  - COLLECT: o_bit_rdy = 1. Transfers shift into the bit register, counted 0..7. The 8th transfer captures i_r and moves to CALC.
  - CALC: 4 cycles, one row per cycle (y1 first), written into the working registers y_work.
  - EMIT: 1 cycle. o_trig = 1, and y_work is copied to o_y_hat on entry. Then moves to HOLD.
  - HOLD: counts GAP cycles, then moves to COLLECT.
- o_y_hat and o_r change only on entry to EMIT. They hold until the next EMIT.
- o_bit_rdy = 0 in CALC, EMIT and HOLD. i_bit_vld is ignored in those states.
- i_r changing outside the capture cycle has no effect.

## Timing
- Reset values:
  - State COLLECT, bit count 0.
  - o_bit_rdy = 1 once reset is released.
  - o_trig = 0, o_y_hat = 0, o_r = 0, y_work = 0.
- Reset mid-frame discards any partial bits or in-progress rows and forces the reset values.
- Latency: if the 8th transfer occurs at edge E, then o_trig is high during the cycle after edge E+4.
- With i_bit_vld held at 1, the trigger period is 8 + 4 + 1 + GAP = 77 cycles (GAP = 64).
- GAP = 0 is legal: EMIT goes directly to COLLECT.
- The HOLD counter width is $clog2(GAP+1).

## Configuration
- ML_MOD_NOISE_EN defined:
  - A 16-bit Galois LFSR (mask 0xB400) with seed 0xACE1, reloaded on reset.
  - The LFSR steps once per CALC cycle.
  - Row k adds sign-extended lfsr[3:0] to re and lfsr[7:4] to im, after scaling and before saturation.
- ML_MOD_NOISE_EN undefined: no LFSR is present, and the output is the exact noiseless result.

## Structure
- Package ml_mod_pkg holds:
  - Width constants: DW = 20, ACC_W = 24.
  - The constant A_Q16 = 46341.
  - Field-offset functions for the R and y packing.
  - The FSM state enum.
- Sub-module ml_mod_row (combinational):
  - Inputs: four R row entries, four symbol sign pairs, and the row index.
  - Output: the scaled and saturated complex yk.
  - It is instantiated once and time-shared across the CALC cycles.

## Test plan
- R = identity (diagonal 65536, off-diagonal 0), bits 0x00 -> every yk = (46341, 46341); o_r equals i_r.
- Same R, bits 0xFF -> every yk = (-46341, -46341).
- Same R, bits b0..b7 = 1,0,0,1,1,1,0,0 -> y1 = (-46341, 46341), y2 = (46341, -46341), y3 = (-46341, -46341), y4 = (46341, 46341).
- All diagonal entries 524287, all off-diagonal entries (524287, 524287), bits 0x00 -> y1.im saturates to 524287 and y1.re = 370727.
- i_bit_vld held at 1 for 300 cycles -> o_trig pulses 77 cycles apart. o_bit_rdy is low for exactly 69 cycles after each 8th bit. o_y_hat changes only in o_trig cycles.
- Reset asserted in the 2nd CALC cycle -> all outputs are 0 and o_trig does not fire. The next 8 bits give correct y.
